// File: rtl/stopwatch_disp_pkg.sv
// Shared types and helpers for the stopwatch display core: FSM states, BCD digit type,
// 7-segment decode table. Raw segment codes are active-high {g,f,e,d,c,b,a}.
package stopwatch_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned NUM_DIG   = 4;
   localparam logic [6:0]  SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   typedef logic [DIGIT_W-1:0] bcd_t;

   function automatic logic [6:0] seg_decode(input bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/stopwatch_disp_if.sv
// Signal bundle between the pulse generator / buttons / display and the stopwatch core.
// master: the surrounding system; slave: stopwatch_disp.
interface stopwatch_disp_if import stopwatch_pkg::*; ();

   logic                          tick_1s;
   logic                          fltr_tick;
   logic                          blink;
   logic [1:0]                    dig_sel;
   logic [NUM_DIG-1:0]            dig_strb;
   logic                          btn_start_n;
   logic                          btn_clr_n;
   logic [6:0]                    seg;
   logic                          dp;
   logic [NUM_DIG-1:0]            an;
   logic                          running;
   logic [NUM_DIG*DIGIT_W-1:0]    digits;

   modport master (
      output tick_1s, fltr_tick, blink, dig_sel, dig_strb, btn_start_n, btn_clr_n,
      input  seg, dp, an, running, digits
   );

   modport slave (
      input  tick_1s, fltr_tick, blink, dig_sel, dig_strb, btn_start_n, btn_clr_n,
      output seg, dp, an, running, digits
   );

endinterface

// File: rtl/stopwatch_disp_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, sample-count debouncer and a 1-clk press pulse
// on the released->pressed transition of the debounced (active-low) level.
module btn_debounce #(
   parameter int unsigned DEB_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic fltr_tick,
   input  logic btn_n,
   output logic press
);

   logic       sync1;
   logic       sync2;
   logic       stable;
   logic [3:0] run_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   // stable=1 is released; press fires in the same edge the pressed level is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable  <= 1'b1;
         run_cnt <= '0;
         press   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (fltr_tick) begin
            if (sync2 != stable) begin
               if (run_cnt == 4'(DEB_LEN - 1)) begin
                  stable  <= sync2;
                  run_cnt <= '0;
                  press   <= ~sync2;
               end else begin
                  run_cnt <= run_cnt + 4'd1;
               end
            end else begin
               run_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_disp.sv
// Stopwatch core: start/pause/clear FSM, 4-digit BCD counter and registered 7-seg mux.
// Define STOPWATCH_MMSS_EN for MM:SS counting with a blinking colon dp on digit 2.
module stopwatch_disp import stopwatch_pkg::*; #(
   parameter int unsigned DEB_LEN = 3,
   parameter int unsigned SEG_INV = 1
) (
   input  logic             clk,
   input  logic             rst,
   stopwatch_disp_if.slave  bus
);

   localparam logic INV = (SEG_INV != 0);

`ifdef STOPWATCH_MMSS_EN
   localparam bcd_t DIGIT_MAX [NUM_DIG] = '{4'd9, 4'd5, 4'd9, 4'd5};
`else
   localparam bcd_t DIGIT_MAX [NUM_DIG] = '{4'd9, 4'd9, 4'd9, 4'd9};
`endif

   logic                       start_ev;
   logic                       clr_ev;
   sw_state_t                  state;
   sw_state_t                  state_nx;
   logic                       running;
   logic [NUM_DIG*DIGIT_W-1:0] count_q;
   logic [NUM_DIG*DIGIT_W-1:0] count_inc;
   logic                       carry;
   bcd_t                       cur_digit;
   logic [6:0]                 seg_raw;
   logic                       dp_raw;
   logic [6:0]                 seg_q;
   logic                       dp_q;
   logic [NUM_DIG-1:0]         an_q;

   btn_debounce #(.DEB_LEN(DEB_LEN)) u_start (
      .clk       (clk),
      .rst       (rst),
      .fltr_tick (bus.fltr_tick),
      .btn_n     (bus.btn_start_n),
      .press     (start_ev)
   );

   btn_debounce #(.DEB_LEN(DEB_LEN)) u_clr (
      .clk       (clk),
      .rst       (rst),
      .fltr_tick (bus.fltr_tick),
      .btn_n     (bus.btn_clr_n),
      .press     (clr_ev)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // clear is checked first so it beats a simultaneous start outside IDLE
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start_ev) state_nx = RUN;
         RUN:     if (clr_ev) state_nx = IDLE; else if (start_ev) state_nx = PAUSE;
         PAUSE:   if (clr_ev) state_nx = IDLE; else if (start_ev) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   assign running = (state == RUN);

   always_comb begin
      count_inc = count_q;
      carry     = 1'b1;
      for (int unsigned i = 0; i < NUM_DIG; i++) begin
         if (carry) begin
            if (count_q[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX[i]) begin
               count_inc[i*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               count_inc[i*DIGIT_W +: DIGIT_W] = count_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          count_q <= '0;
      else if (state_nx == IDLE)        count_q <= '0;
      else if (running && bus.tick_1s)  count_q <= count_inc;
   end

   always_comb begin
      cur_digit = count_q[{bus.dig_sel, 2'b00} +: DIGIT_W];
      seg_raw   = seg_decode(cur_digit);
`ifdef STOPWATCH_MMSS_EN
      dp_raw    = (bus.dig_sel == 2'd2) ? (running ? bus.blink : 1'b1) : 1'b0;
`else
      dp_raw    = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= {7{INV}};
         dp_q  <= INV;
         an_q  <= {NUM_DIG{INV}};
      end else begin
         seg_q <= seg_raw ^ {7{INV}};
         dp_q  <= dp_raw ^ INV;
         an_q  <= bus.dig_strb ^ {NUM_DIG{INV}};
      end
   end

   assign bus.seg     = seg_q;
   assign bus.dp      = dp_q;
   assign bus.an      = an_q;
   assign bus.running = running;
   assign bus.digits  = count_q;

endmodule
